lab1_imul_result_queue: RTL and testbench

//   Normalizing result queue directly downstream of the integer multiplier.

---
 rtl/lab1_imul_result_queue.sv | 92 +++++++++
 tb/tb_lab1_imul_result_queue.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/lab1_imul_result_queue.sv
// Result queue behind the integer multiplier: circular-buffer FIFO, 1-cycle latency, 1 msg/cycle; optional 0-cycle bypass via LAB1_IMUL_RESULT_QUEUE_BYPASS_EN.
// Backpressure: enq_rdy depends only on occupancy (count != N), never on deq_rdy.
module lab1_imul_result_queue #(
    parameter int p_nbits       = 32,
    parameter int p_num_entries = 4
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               enq_val,
    output logic                               enq_rdy,
    input  logic [p_nbits-1:0]                 enq_msg,
    output logic                               deq_val,
    input  logic                               deq_rdy,
    output logic [p_nbits-1:0]                 deq_msg,
    output logic [$clog2(p_num_entries+1)-1:0] num_free
);

    localparam int PW = $clog2(p_num_entries);
    localparam int CW = $clog2(p_num_entries + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(p_num_entries);

    logic [p_nbits-1:0] mem_q [p_num_entries];
    logic [PW-1:0]      enq_ptr_q, enq_ptr_d;
    logic [PW-1:0]      deq_ptr_q, deq_ptr_d;
    logic [CW-1:0]      count_q, count_d;

    logic empty;
    logic enq_fire;
    logic deq_fire;
    logic do_write;
    logic do_read;

    assign empty    = (count_q == '0);
    assign enq_rdy  = (count_q != FULL_CNT);
    assign num_free = FULL_CNT - count_q;
    assign enq_fire = enq_val & enq_rdy;

`ifdef LAB1_IMUL_RESULT_QUEUE_BYPASS_EN
    logic pass_thru;

    // An empty queue forwards the incoming result straight to the consumer.
    assign deq_val   = ~empty | enq_val;
    assign deq_msg   = empty ? enq_msg : mem_q[deq_ptr_q];
    assign deq_fire  = deq_val & deq_rdy;
    assign pass_thru = empty & enq_val & deq_rdy;
    assign do_write  = enq_fire & ~pass_thru;
    assign do_read   = deq_fire & ~pass_thru;
`else
    assign deq_val  = ~empty;
    assign deq_msg  = mem_q[deq_ptr_q];
    assign deq_fire = deq_val & deq_rdy;
    assign do_write = enq_fire;
    assign do_read  = deq_fire;
`endif

    always_comb begin
        enq_ptr_d = enq_ptr_q;
        deq_ptr_d = deq_ptr_q;
        count_d   = count_q;
        if (do_write) begin
            enq_ptr_d = enq_ptr_q + 1'b1;
        end
        if (do_read) begin
            deq_ptr_d = deq_ptr_q + 1'b1;
        end
        if (do_write && !do_read) begin
            count_d = count_q + 1'b1;
        end else if (!do_write && do_read) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            enq_ptr_q <= '0;
            deq_ptr_q <= '0;
            count_q   <= '0;
        end else begin
            enq_ptr_q <= enq_ptr_d;
            deq_ptr_q <= deq_ptr_d;
            count_q   <= count_d;
        end
    end

    // Storage is deliberately not reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem_q[enq_ptr_q] <= enq_msg;
        end
    end

endmodule

// File: tb/tb_lab1_imul_result_queue.sv
// Bench for lab1_imul_result_queue: directed scenarios plus random traffic against a queue-based model.
module tb_lab1_imul_result_queue;

    localparam int N = 4;
`ifdef LAB1_IMUL_RESULT_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        enq_val = 1'b0;
    logic        enq_rdy;
    logic [31:0] enq_msg = '0;
    logic        deq_val;
    logic        deq_rdy = 1'b0;
    logic [31:0] deq_msg;
    logic [2:0]  num_free;

    int checks = 0;
    int failures = 0;
    logic [31:0] mq[$];

    logic        e_val, e_rdy;
    logic [2:0]  e_free;
    logic [31:0] e_msg;

    always #5 clk = ~clk;

    lab1_imul_result_queue #(.p_nbits(32), .p_num_entries(N)) dut (
        .clk(clk), .reset(reset),
        .enq_val(enq_val), .enq_rdy(enq_rdy), .enq_msg(enq_msg),
        .deq_val(deq_val), .deq_rdy(deq_rdy), .deq_msg(deq_msg),
        .num_free(num_free)
    );

    // Expected outputs from the model queue and the current inputs.
    task automatic model_outs();
        int sz = mq.size();
        e_rdy  = (sz != N);
        e_free = 3'(N - sz);
        e_val  = (sz != 0) || (BYP && enq_val);
        e_msg  = (sz != 0) ? mq[0] : enq_msg;
    endtask

    task automatic drive(input logic ev, input logic [31:0] em, input logic dr);
        enq_val = ev;
        enq_msg = em;
        deq_rdy = dr;
        #1;
        model_outs();
    endtask

    task automatic tick();
        int sz = mq.size();
        bit ef, df, pass;
        logic [31:0] m;
        m    = enq_msg;
        pass = BYP && (sz == 0) && enq_val && deq_rdy;
        ef   = enq_val && (sz != N);
        df   = deq_rdy && (sz != 0);
        @(posedge clk);
        if (!pass) begin
            if (df) void'(mq.pop_front());
            if (ef) mq.push_back(m);
        end
        @(negedge clk);
    endtask

    task automatic drain();
        while (mq.size() != 0) begin
            drive(1'b0, '0, 1'b1);
            tick();
        end
        drive(1'b0, '0, 1'b0);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        checks++; if (enq_rdy !== 1'b1) begin failures++; $display("FAIL rst_enq_rdy got %b exp 1", enq_rdy); end
        checks++; if (deq_val !== 1'b0) begin failures++; $display("FAIL rst_deq_val got %b exp 0", deq_val); end
        checks++; if (num_free !== 3'd4) begin failures++; $display("FAIL rst_num_free got %0d exp 4", num_free); end
        reset = 1'b1;
        #1;
        checks++; if (deq_val !== 1'b0 || enq_rdy !== 1'b1 || num_free !== 3'd4) begin
            failures++; $display("FAIL rst_release got val=%b rdy=%b free=%0d exp 0/1/4", deq_val, enq_rdy, num_free); end
        @(posedge clk); @(negedge clk); #1;
        checks++; if (deq_val !== 1'b0 || enq_rdy !== 1'b1 || num_free !== 3'd4) begin
            failures++; $display("FAIL rst_idle got val=%b rdy=%b free=%0d exp 0/1/4", deq_val, enq_rdy, num_free); end
        @(negedge clk);
    endtask

    task automatic test_fill_drain();
        logic [31:0] v[4];
        v[0] = 32'h0000_0006; v[1] = 32'h0000_000F; v[2] = 32'hFFFF_FFFE; v[3] = 32'h0000_0001;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, v[i], 1'b0);
            checks++; if (num_free !== 3'(4 - i)) begin failures++; $display("FAIL fill_free[%0d] got %0d exp %0d", i, num_free, 4 - i); end
            tick();
        end
        drive(1'b0, '0, 1'b0);
        checks++; if (enq_rdy !== 1'b0) begin failures++; $display("FAIL full_enq_rdy got %b exp 0", enq_rdy); end
        checks++; if (num_free !== 3'd0) begin failures++; $display("FAIL full_num_free got %0d exp 0", num_free); end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, '0, 1'b1);
            checks++; if (deq_val !== 1'b1 || deq_msg !== v[i]) begin
                failures++; $display("FAIL drain[%0d] got val=%b msg=%h exp 1/%h", i, deq_val, deq_msg, v[i]); end
            tick();
        end
        drive(1'b0, '0, 1'b0);
        checks++; if (deq_val !== 1'b0) begin failures++; $display("FAIL drained_deq_val got %b exp 0", deq_val); end
    endtask

    task automatic test_full_stream();
        int accepted = 0;
        int cyc = 0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, $urandom, 1'b0);
            tick();
        end
        drive(1'b1, 32'hA5A5_0000, 1'b1);
        checks++; if (enq_rdy !== 1'b0) begin failures++; $display("FAIL full_pipe_rdy got %b exp 0", enq_rdy); end
        tick();
        drive(1'b1, 32'hA5A5_0001, 1'b0);
        checks++; if (num_free !== 3'd1) begin failures++; $display("FAIL full_pipe_free got %0d exp 1", num_free); end
        checks++; if (enq_rdy !== 1'b1) begin failures++; $display("FAIL full_pipe_next_rdy got %b exp 1", enq_rdy); end
        tick();
        while (accepted < 10 && cyc < 100) begin
            drive(1'b1, $urandom, (cyc % 2) == 0);
            if (enq_rdy === 1'b1) accepted++;
            checks++; if (deq_val !== e_val || enq_rdy !== e_rdy || num_free !== e_free) begin
                failures++; $display("FAIL stream_ctl[%0d] got val=%b rdy=%b free=%0d exp %b/%b/%0d", cyc, deq_val, enq_rdy, num_free, e_val, e_rdy, e_free); end
            if (e_val) begin
                checks++; if (deq_msg !== e_msg) begin failures++; $display("FAIL stream_msg[%0d] got %h exp %h", cyc, deq_msg, e_msg); end
            end
            tick();
            cyc++;
        end
        checks++; if (accepted != 10) begin failures++; $display("FAIL stream_budget got %0d accepted exp 10", accepted); end
        drain();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, $urandom, 1'b0);
            tick();
        end
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, $urandom, 1'b1);
            checks++; if (num_free !== 3'd2 || deq_val !== 1'b1 || deq_msg !== e_msg) begin
                failures++; $display("FAIL b2b[%0d] got free=%0d val=%b msg=%h exp 2/1/%h", i, num_free, deq_val, deq_msg, e_msg); end
            tick();
        end
        drain();
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, $urandom, 1'b0);
            tick();
        end
        drive(1'b0, '0, 1'b0);
        checks++; if (num_free !== 3'd1) begin failures++; $display("FAIL mid_pre_free got %0d exp 1", num_free); end
        reset = 1'b0;
        #1;
        checks++; if (deq_val !== 1'b0 || num_free !== 3'd4 || enq_rdy !== 1'b1) begin
            failures++; $display("FAIL mid_reset got val=%b free=%0d rdy=%b exp 0/4/1", deq_val, num_free, enq_rdy); end
        mq.delete();
        reset = 1'b1;
        drive(1'b1, 32'h1234_5678, 1'b0);
        tick();
        drive(1'b0, '0, 1'b1);
        checks++; if (deq_val !== 1'b1 || deq_msg !== 32'h1234_5678) begin
            failures++; $display("FAIL mid_first_out got val=%b msg=%h exp 1/12345678", deq_val, deq_msg); end
        tick();
        drive(1'b0, '0, 1'b0);
        checks++; if (deq_val !== 1'b0) begin failures++; $display("FAIL mid_empty got %b exp 0", deq_val); end
    endtask

    task automatic test_bypass();
        drive(1'b1, 32'hDEAD_BEEF, 1'b1);
        if (BYP) begin
            checks++; if (deq_val !== 1'b1 || deq_msg !== 32'hDEAD_BEEF) begin
                failures++; $display("FAIL byp_same_cycle got val=%b msg=%h exp 1/deadbeef", deq_val, deq_msg); end
            tick();
            drive(1'b0, '0, 1'b0);
            checks++; if (num_free !== 3'd4 || deq_val !== 1'b0) begin
                failures++; $display("FAIL byp_after got free=%0d val=%b exp 4/0", num_free, deq_val); end
        end else begin
            checks++; if (deq_val !== 1'b0) begin failures++; $display("FAIL nobyp_same_cycle got val=%b exp 0", deq_val); end
            tick();
            drive(1'b0, '0, 1'b1);
            checks++; if (deq_val !== 1'b1 || deq_msg !== 32'hDEAD_BEEF) begin
                failures++; $display("FAIL nobyp_next got val=%b msg=%h exp 1/deadbeef", deq_val, deq_msg); end
            tick();
        end
        drain();
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) != 0);
            checks++; if (deq_val !== e_val || enq_rdy !== e_rdy || num_free !== e_free) begin
                failures++; $display("FAIL rand_ctl[%0d] got val=%b rdy=%b free=%0d exp %b/%b/%0d", i, deq_val, enq_rdy, num_free, e_val, e_rdy, e_free); end
            if (e_val) begin
                checks++; if (deq_msg !== e_msg) begin failures++; $display("FAIL rand_msg[%0d] got %h exp %h", i, deq_msg, e_msg); end
            end
            tick();
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_full_stream();
        test_back_to_back();
        test_reset_mid();
        test_bypass();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
